// File: rtl/sdram_nios2_qsys_div_cell_if.sv
// Operand/result bundle between the CPU execute stage and the divide cell.
//
// Handshake: the master raises A_div_start with operands valid in the same
// cycle; the request is taken on the rising edge only when A_div_busy is low
// (start acts as valid, !busy as ready). No request is queued: a start seen
// while busy is dropped. A_div_done pulses for one cycle with the results,
// which then stay put until the next accepted start completes.
interface sdram_nios2_qsys_div_cell_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A_div_src1;
    logic [WIDTH-1:0] A_div_src2;
    logic             A_div_signed;
    logic             A_div_start;
    logic             A_div_busy;
    logic             A_div_done;
    logic [WIDTH-1:0] A_div_quotient;
    logic [WIDTH-1:0] A_div_remainder;
    logic             A_div_by_zero;

    modport master (
        output A_div_src1, A_div_src2, A_div_signed, A_div_start,
        input  A_div_busy, A_div_done, A_div_quotient, A_div_remainder,
        input  A_div_by_zero
    );

    modport slave (
        input  A_div_src1, A_div_src2, A_div_signed, A_div_start,
        output A_div_busy, A_div_done, A_div_quotient, A_div_remainder,
        output A_div_by_zero
    );
endinterface

// File: rtl/sdram_nios2_qsys_div_cell.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle on the
// operand magnitudes, then a single sign-fixup cycle. Fixed latency of
// WIDTH+2 cycles from acceptance to the done pulse.
module sdram_nios2_qsys_div_cell #(
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    sdram_nios2_qsys_div_cell_if.slave   div_if,
    output logic [1:0]                   dbg_state
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;        // partial remainder
    logic [WIDTH-1:0] dvd_q, dvd_d;        // dividend bits out, quotient bits in
    logic [WIDTH-1:0] dvs_q, dvs_d;        // divisor magnitude
    logic [WIDTH-1:0] src1_q, src1_d;      // raw dividend for the divide-by-zero result
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remd_q, remd_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic             src1_neg;
    logic             src2_neg;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;

    // Request is taken only in the states where the cell is not busy.
    assign accept   = div_if.A_div_start && (state_q == S_IDLE || state_q == S_DONE);
    assign src1_neg = div_if.A_div_signed & div_if.A_div_src1[WIDTH-1];
    assign src2_neg = div_if.A_div_signed & div_if.A_div_src2[WIDTH-1];

    // Shifted partial remainder and the trial subtraction at WIDTH+1 bits;
    // bit WIDTH of the trial is the borrow that decides restore vs keep.
    assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, dvs_q};

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        src1_d    = src1_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        zero_d    = zero_q;
        quot_d    = quot_q;
        remd_d    = remd_q;
        dbz_d     = dbz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    quo_neg_d = src1_neg ^ src2_neg;
                    rem_neg_d = src1_neg;
                    dvd_d     = src1_neg ? -div_if.A_div_src1 : div_if.A_div_src1;
                    dvs_d     = src2_neg ? -div_if.A_div_src2 : div_if.A_div_src2;
                    src1_d    = div_if.A_div_src1;
                    zero_d    = (div_if.A_div_src2 == '0);
                    rem_d     = '0;
                    cnt_d     = CW'(WIDTH - 1);
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                if (zero_q) begin
                    quot_d = '1;
                    remd_d = src1_q;
                end else begin
                    quot_d = quo_neg_q ? -dvd_q : dvd_q;
                    remd_d = rem_neg_q ? -rem_q : rem_q;
                end
                dbz_d   = zero_q;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            src1_q    <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            zero_q    <= 1'b0;
            quot_q    <= '0;
            remd_q    <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            src1_q    <= src1_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            zero_q    <= zero_d;
            quot_q    <= quot_d;
            remd_q    <= remd_d;
            dbz_q     <= dbz_d;
        end
    end

    assign div_if.A_div_busy      = (state_q == S_CALC) || (state_q == S_FIXUP);
    assign div_if.A_div_done      = (state_q == S_DONE);
    assign div_if.A_div_quotient  = quot_q;
    assign div_if.A_div_remainder = remd_q;
    assign div_if.A_div_by_zero   = dbz_q;
    assign dbg_state              = state_q;
endmodule

// File: tb/tb_sdram_nios2_qsys_div_cell.sv
// Bench for the divide cell: directed operations with literal expectations,
// plus a transaction-level reference checked against the outputs each cycle.
module tb_sdram_nios2_qsys_div_cell;
    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic       clk;
    logic       reset_n;
    logic [1:0] dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    sdram_nios2_qsys_div_cell_if #(.WIDTH(W)) div_if ();

    sdram_nios2_qsys_div_cell #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .div_if    (div_if.slave),
        .dbg_state (dbg_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference arithmetic: truncating division with the cell's special cases.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic bz);
        bz = (b == 0);
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = '0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Transaction-level model: age counts cycles since acceptance (0 = none).
    int         m_age = 0;
    logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    logic       m_bz = 1'b0, p_bz = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_age = 0;
            m_q   = '0;
            m_r   = '0;
            m_bz  = 1'b0;
        end else begin
            if (div_if.A_div_start && (m_age == 0 || m_age == LAT)) begin
                ref_div(div_if.A_div_src1, div_if.A_div_src2, div_if.A_div_signed, p_q, p_r, p_bz);
                m_age = 1;
            end else if (m_age == LAT) begin
                m_age = 0;
            end else if (m_age != 0) begin
                m_age++;
                if (m_age == LAT) begin
                    m_q  = p_q;
                    m_r  = p_r;
                    m_bz = p_bz;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            check("cyc_busy", {31'd0, div_if.A_div_busy}, {31'd0, (m_age >= 1 && m_age <= LAT - 1)});
            check("cyc_done", {31'd0, div_if.A_div_done}, {31'd0, (m_age == LAT)});
            check("cyc_quot", div_if.A_div_quotient, m_q);
            check("cyc_rem",  div_if.A_div_remainder, m_r);
            check("cyc_dbz",  {31'd0, div_if.A_div_by_zero}, {31'd0, m_bz});
        end
    end

    // Present a request for one cycle; returns in cycle 1 of the operation.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(posedge clk);
        #1;
        div_if.A_div_src1   = a;
        div_if.A_div_src2   = b;
        div_if.A_div_signed = s;
        div_if.A_div_start  = 1'b1;
        @(posedge clk);
        #1;
        div_if.A_div_start  = 1'b0;
    endtask

    // Bounded wait for done; cyc_n is the cycle number relative to acceptance.
    task automatic wait_done(output int cyc_n, output int busy_n);
        cyc_n  = -1;
        busy_n = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (div_if.A_div_busy) busy_n++;
            if (div_if.A_div_done) begin
                cyc_n = k;
                return;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic ebz);
        int c, bc;
        issue(a, b, s);
        wait_done(c, bc);
        check({name, "_lat"}, c, LAT);
        check({name, "_busycnt"}, bc, LAT - 1);
        check({name, "_q"}, div_if.A_div_quotient, eq);
        check({name, "_r"}, div_if.A_div_remainder, er);
        check({name, "_bz"}, {31'd0, div_if.A_div_by_zero}, {31'd0, ebz});
    endtask

    // Directed stimulus
    initial begin
        int c, bc;
        div_if.A_div_src1   = '0;
        div_if.A_div_src2   = '0;
        div_if.A_div_signed = 1'b0;
        div_if.A_div_start  = 1'b0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, div_if.A_div_busy}, 32'd0);
        check("rst_done", {31'd0, div_if.A_div_done}, 32'd0);
        check("rst_quot", div_if.A_div_quotient, 32'd0);
        check("rst_rem",  div_if.A_div_remainder, 32'd0);
        check("rst_dbz",  {31'd0, div_if.A_div_by_zero}, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        run_op("u100_7",   32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0);
        run_op("sm7_2",    32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
        run_op("s7_m2",    32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0);
        run_op("dz_s",     32'h1234_5678,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h1234_5678,  1'b1);
        run_op("dz_u",     32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234_5678,  1'b1);
        run_op("ovf_s",    32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0);
        run_op("ovf_u",    32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0);

        // Start while busy is dropped; start held in the done cycle is taken.
        issue(32'd1000, 32'd10, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        div_if.A_div_src1  = 32'd5;
        div_if.A_div_src2  = 32'd5;
        div_if.A_div_start = 1'b1;
        @(posedge clk);
        #1 div_if.A_div_start = 1'b0;
        repeat (23) @(posedge clk);
        #1;
        check("hs_done34", {31'd0, div_if.A_div_done}, 32'd1);
        check("hs_q",      div_if.A_div_quotient, 32'd100);
        check("hs_r",      div_if.A_div_remainder, 32'd0);
        div_if.A_div_src1   = 32'hFFFF_FF9C;
        div_if.A_div_src2   = 32'd7;
        div_if.A_div_signed = 1'b1;
        div_if.A_div_start  = 1'b1;
        @(posedge clk);
        #1 div_if.A_div_start = 1'b0;
        wait_done(c, bc);
        check("b2b_lat68", c + LAT, 2 * LAT);
        check("b2b_q", div_if.A_div_quotient, 32'hFFFF_FFF2);
        check("b2b_r", div_if.A_div_remainder, 32'hFFFF_FFFE);

        // Reset in the middle of an operation.
        issue(32'hDEAD_BEEF, 32'd3, 1'b0);
        repeat (14) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("mid_busy", {31'd0, div_if.A_div_busy}, 32'd0);
        check("mid_done", {31'd0, div_if.A_div_done}, 32'd0);
        check("mid_quot", div_if.A_div_quotient, 32'd0);
        check("mid_rem",  div_if.A_div_remainder, 32'd0);
        check("mid_dbz",  {31'd0, div_if.A_div_by_zero}, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (25) @(posedge clk);
        run_op("post_rst", 32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'hF, 1'b0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sdram_nios2_qsys_div_cell.md
# sdram_nios2_qsys_div_cell

Iterative radix-2 restoring divider for the Nios II custom arithmetic path. It produces the 32-bit quotient and remainder for signed or unsigned operands. It sits beside the pipelined multiply cell in the CPU execute stage and serves `div`/`divu` (quotient) and remainder sequences. The CPU holds the instruction until a one-cycle `done` pulse.

## Interface
- `WIDTH`, 32: operand, quotient and remainder width. Must be 2 or greater.
- `clk`  in  1  Single clock. All state updates on the rising edge.
- `reset_n`  in  1  Reset, asynchronous and active-low.
- `A_div_src1`  in  WIDTH  Dividend. Sampled only on an accepted start.
- `A_div_src2`  in  WIDTH  Divisor. Sampled only on an accepted start.
- `A_div_signed`  in  1  1 = two's-complement operands, 0 = unsigned. Sampled on an accepted start.
- `A_div_start`  in  1  Request. Accepted only when `A_div_busy`=0.
- `A_div_busy`  out  1  High from the cycle after acceptance until `A_div_done` asserts.
- `A_div_done`  out  1  One-cycle pulse. Results are valid in this cycle.
- `A_div_quotient`  out  WIDTH  Quotient. Held until the next accepted start.
- `A_div_remainder`  out  WIDTH  Remainder. Held until the next accepted start.
- `A_div_by_zero`  out  1  Divisor was zero. Valid with the results and held with them.

## Operation
- States: IDLE, CALC, FIXUP, DONE.
- IDLE/DONE, on `A_div_start`=1:
  - Latch the sign flags: `neg_q` = signed & (src1 MSB xor src2 MSB); `neg_r` = signed & src1 MSB.
  - Latch the magnitudes: |src1| and |src2| when signed, raw values otherwise.
  - Latch `by_zero` = (src2 == 0).
  - Clear the partial remainder, load the iteration counter with WIDTH-1, go to CALC.
- CALC, once per cycle:
  - Shift {rem, dvd} left by 1.
  - Trial subtract: rem_shifted − divisor, computed at WIDTH+1 bits.
  - If the result is non-negative, keep it and shift in quotient bit 1. Otherwise restore and shift in 0.
  - Decrement the counter. When counter==0 after this iteration, go to FIXUP.
- FIXUP, one cycle:
  - Quotient = neg_q ? −q : q. Remainder = neg_r ? −r : r.
  - If by_zero, override: quotient = all ones, remainder = original src1 (unsigned value of the latched operand, no sign fixup).
  - Register the outputs and go to DONE.
- DONE:
  - `A_div_done`=1 for exactly this cycle.
  - Next state is CALC if a new start is accepted, else IDLE.
- Start while busy (CALC/FIXUP) is ignored, with no queuing. The operand inputs are don't-care outside acceptance.
- Arithmetic rules:
  - Truncating division: the remainder takes the dividend's sign, and |r| < |divisor|.
  - Signed overflow (−2^(W−1) / −1) yields quotient 0x80000000, remainder 0, `by_zero`=0.
- Reset (async assert, any state):
  - State returns to IDLE.
  - `A_div_busy`=0, `A_div_done`=0, `A_div_quotient`=0, `A_div_remainder`=0, `A_div_by_zero`=0.
  - Any in-flight operation is discarded, with no done pulse.
  - Release is synchronous to `clk` at the system level.

## Timing
- Call the start-acceptance cycle cycle 0.
- CALC occupies cycles 1..WIDTH, FIXUP is cycle WIDTH+1, and DONE/`A_div_done` is cycle WIDTH+2 (34 for WIDTH=32). The latency is fixed and does not depend on operand values or division by zero.
- `A_div_busy` is high in cycles 1..WIDTH+1 and low in DONE, so back-to-back issue is allowed.
- Maximum throughput is one result per WIDTH+2 cycles.
- Outputs change only at the FIXUP→DONE edge, or on reset. They are stable through IDLE and through the CALC cycles of the next operation.

## Test plan
- Unsigned 100 / 7 (signed=0), start in cycle 0 → done only in cycle 34; quotient 14, remainder 2, by_zero 0; busy high in cycles 1..33.
- Signed −7 / 2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- 0x12345678 / 0, both signed and unsigned → quotient 0xFFFFFFFF, remainder 0x12345678, by_zero 1, done in cycle 34.
- 0x80000000 / 0xFFFFFFFF signed → quotient 0x80000000, remainder 0. Same operands unsigned → quotient 0, remainder 0x80000000.
- Handshake sequence:
  - Pulse start again at cycle 10 with different operands → ignored; the first result is unchanged.
  - Start held high in the DONE cycle → second operation accepted; its done arrives at cycle 68.
- Reset mid-operation:
  - Assert reset_n=0 at cycle 15 → outputs all 0 immediately; no done pulse.
  - After release, 0xFFFFFFFF / 0x10 unsigned → quotient 0x0FFFFFFF, remainder 0xF.
